// File: rtl/vram_wr_ctrl_if.sv
// Packet-in / VRAM-write-out bundle for vram_wr_ctrl.
// The slave side is the controller; the master side is the packet source and VRAM.
interface vram_wr_ctrl_if #(
  parameter int AW = 17
);
  logic [7:0]    data_in;
  logic          data_en;
  logic [AW-1:0] addr2vram;
  logic [7:0]    data_rgb;
  logic          wea_r;
  logic          wea_g;
  logic          wea_b;
  logic          frame_done;
  logic          busy;
  logic [7:0]    err_cnt;

  modport master (
    output data_in, data_en,
    input  addr2vram, data_rgb, wea_r, wea_g, wea_b, frame_done, busy, err_cnt
  );

  modport slave (
    input  data_in, data_en,
    output addr2vram, data_rgb, wea_r, wea_g, wea_b, frame_done, busy, err_cnt
  );
endinterface

// File: rtl/vram_wr_ctrl.sv
// Writes one video line per received packet into three VRAM colour planes.
// Header is a 16-bit line number; payload is R,G,B bytes per pixel.
module vram_wr_ctrl #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int AW      = 17
) (
  input  logic           clk,
  input  logic           RST,
  vram_wr_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PIX, DROP} state_t;

  localparam logic [15:0] V_LINES_W = 16'(V_LINES);
  localparam logic [15:0] LAST_LINE = 16'(V_LINES - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(H_PIX - 1);

  state_t        state;
  logic [7:0]    byte0;
  logic [AW-1:0] base;
  logic [AW-1:0] pix;
  logic [1:0]    plane;
  logic          last_line;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          wea_r_q, wea_g_q, wea_b_q;
  logic          frame_done_q;
  logic [7:0]    err_q;

  logic [15:0]   line;
  logic          byte_last;
  logic [7:0]    err_next;

  assign line      = {byte0, bus.data_in};
  assign byte_last = (pix == PIX_LAST) && (plane == 2'd2);
  assign err_next  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= HDR0;
      byte0        <= '0;
      base         <= '0;
      pix          <= '0;
      plane        <= '0;
      last_line    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wea_r_q      <= 1'b0;
      wea_g_q      <= 1'b0;
      wea_b_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      wea_r_q      <= 1'b0;
      wea_g_q      <= 1'b0;
      wea_b_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_en) begin
            byte0 <= bus.data_in;
            state <= HDR1;
          end
        end
        HDR0: begin
          if (!bus.data_en) state <= IDLE;
        end
        HDR1: begin
          if (!bus.data_en) begin
            err_q <= err_next;
            state <= IDLE;
          end else if (line < V_LINES_W) begin
            base      <= AW'(line) * AW'(H_PIX);
            pix       <= '0;
            plane     <= '0;
            last_line <= (line == LAST_LINE);
            state     <= PIX;
          end else begin
            err_q <= err_next;
            state <= DROP;
          end
        end
        PIX: begin
          if (!bus.data_en) begin
            err_q <= err_next;
            state <= IDLE;
          end else begin
            addr_q  <= base + pix;
            data_q  <= bus.data_in;
            wea_r_q <= (plane == 2'd0);
            wea_g_q <= (plane == 2'd1);
            wea_b_q <= (plane == 2'd2);
            if (plane == 2'd2) begin
              plane <= 2'd0;
              pix   <= pix + 1'b1;
            end else begin
              plane <= plane + 2'd1;
            end
            // A full line parks in DROP so any surplus bytes are swallowed silently.
            if (byte_last) begin
              frame_done_q <= last_line;
              state        <= DROP;
            end
          end
        end
        DROP: begin
          if (!bus.data_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr2vram  = addr_q;
  assign bus.data_rgb   = data_q;
  assign bus.wea_r      = wea_r_q;
  assign bus.wea_g      = wea_g_q;
  assign bus.wea_b      = wea_b_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE);
  assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_vram_wr_ctrl.sv
// Directed bench for vram_wr_ctrl: a negedge monitor logs every strobe,
// and each test task checks the log and the status outputs against hand-computed values.
module tb_vram_wr_ctrl;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;

  vram_wr_ctrl_if #(.AW(AW)) bus ();

  vram_wr_ctrl #(.H_PIX(320), .V_LINES(240), .AW(AW)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            plane;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } rec_t;

  rec_t q[$];
  int   fd_cnt = 0;
  logic [AW-1:0] fd_addr = '0;
  logic fd_web = 1'b0;
  int   multi = 0;
  int   acc_cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    rec_t r;
    if ((bus.wea_r & bus.wea_g) | (bus.wea_r & bus.wea_b) | (bus.wea_g & bus.wea_b))
      multi++;
    if (bus.wea_r | bus.wea_g | bus.wea_b) begin
      r.plane = bus.wea_g ? 1 : (bus.wea_b ? 2 : 0);
      r.addr  = bus.addr2vram;
      r.data  = bus.data_rgb;
      r.cyc   = cyc;
      q.push_back(r);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_addr = bus.addr2vram;
      fd_web  = bus.wea_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bus.data_in = b;
    bus.data_en = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input int line, input int npay, input bit hold);
    logic [7:0] b;
    drive_byte(line[15:8]);
    drive_byte(line[7:0]);
    for (int k = 0; k < npay; k++) begin
      b = k[7:0];
      drive_byte(b);
      if (k == 0) acc_cyc = cyc;
    end
    if (!hold) begin
      bus.data_en = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.data_en = 1'b0;
    bus.data_in = 8'h00;
    tick();
    tick();
    RST = 1'b0;
    tick();
    q.delete();
    fd_cnt = 0;
    multi  = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.data_en = 1'b0;
    bus.data_in = 8'h00;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    total++;
    if ({bus.wea_r, bus.wea_g, bus.wea_b, bus.frame_done} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.wea_r, bus.wea_g, bus.wea_b, bus.frame_done});
    end
    total++;
    if (bus.err_cnt !== 8'd0 || bus.addr2vram !== '0 || bus.data_rgb !== 8'd0) begin
      bad++; $display("FAIL reset_regs err=%0d addr=%0d data=%0d exp=0/0/0", bus.err_cnt, bus.addr2vram, bus.data_rgb);
    end
    RST = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_exit_idle busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_line5();
    do_reset();
    send_pkt(5, 960, 1'b0);
    total++;
    if (q.size() !== 960) begin bad++; $display("FAIL line5_count got=%0d exp=960", q.size()); end
    if (q.size() == 960) begin
      total++;
      if (q[0].plane != 0 || q[0].addr !== 17'd1600 || q[0].data !== 8'h00) begin
        bad++; $display("FAIL line5_first plane=%0d addr=%0d data=%h exp=0/1600/00", q[0].plane, q[0].addr, q[0].data);
      end
      total++;
      if (q[959].plane != 2 || q[959].addr !== 17'd1919 || q[959].data !== 8'hBF) begin
        bad++; $display("FAIL line5_last plane=%0d addr=%0d data=%h exp=2/1919/bf", q[959].plane, q[959].addr, q[959].data);
      end
      total++;
      if (q[0].cyc != acc_cyc) begin bad++; $display("FAIL line5_latency strobe_cyc=%0d exp=%0d", q[0].cyc, acc_cyc); end
      total++;
      if (q[4].plane != 1 || q[4].addr !== 17'd1601 || q[4].data !== 8'h04) begin
        bad++; $display("FAIL line5_pix1g plane=%0d addr=%0d data=%h exp=1/1601/04", q[4].plane, q[4].addr, q[4].data);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd0 || fd_cnt != 0 || multi != 0) begin
      bad++; $display("FAIL line5_status err=%0d fd=%0d multi=%0d exp=0/0/0", bus.err_cnt, fd_cnt, multi);
    end
  endtask

  task automatic test_frame_done();
    do_reset();
    send_pkt(239, 960, 1'b0);
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL fd_count got=%0d exp=1", fd_cnt); end
    total++;
    if (fd_web !== 1'b1 || fd_addr !== 17'd76799) begin
      bad++; $display("FAIL fd_coincident web=%b addr=%0d exp=1/76799", fd_web, fd_addr);
    end
    total++;
    if (q.size() !== 960) begin bad++; $display("FAIL fd_strobes got=%0d exp=960", q.size()); end
  endtask

  task automatic test_bad_line();
    do_reset();
    send_pkt(240, 960, 1'b1);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL badline_busy got=%b exp=1", bus.busy); end
    bus.data_en = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL badline_idle busy=%b exp=0", bus.busy); end
    tick();
    total++;
    if (q.size() !== 0 || bus.err_cnt !== 8'd1) begin
      bad++; $display("FAIL badline_result strobes=%0d err=%0d exp=0/1", q.size(), bus.err_cnt);
    end
  endtask

  task automatic test_truncated();
    do_reset();
    send_pkt(0, 4, 1'b0);
    total++;
    if (q.size() !== 4) begin bad++; $display("FAIL trunc_count got=%0d exp=4", q.size()); end
    if (q.size() == 4) begin
      total++;
      if (q[0].plane != 0 || q[0].addr !== 17'd0 || q[0].data !== 8'h00 ||
          q[1].plane != 1 || q[1].addr !== 17'd0 || q[1].data !== 8'h01 ||
          q[2].plane != 2 || q[2].addr !== 17'd0 || q[2].data !== 8'h02 ||
          q[3].plane != 0 || q[3].addr !== 17'd1 || q[3].data !== 8'h03) begin
        bad++; $display("FAIL trunc_seq p/a=%0d/%0d %0d/%0d %0d/%0d %0d/%0d exp=0/0 1/0 2/0 0/1",
                        q[0].plane, q[0].addr, q[1].plane, q[1].addr, q[2].plane, q[2].addr, q[3].plane, q[3].addr);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL trunc_err err=%0d busy=%b exp=1/0", bus.err_cnt, bus.busy);
    end
    send_pkt(3, 960, 1'b0);
    total++;
    if (q.size() !== 964) begin bad++; $display("FAIL trunc_next_count got=%0d exp=964", q.size()); end
    else begin
      total++;
      if (q[963].addr !== 17'd1279 || q[963].plane != 2 || q[4].addr !== 17'd960) begin
        bad++; $display("FAIL trunc_next_addr first=%0d last=%0d exp=960/1279", q[4].addr, q[963].addr);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL trunc_next_err got=%0d exp=1", bus.err_cnt); end
  endtask

  task automatic test_surplus();
    do_reset();
    send_pkt(1, 965, 1'b0);
    total++;
    if (q.size() !== 960) begin bad++; $display("FAIL surplus_count got=%0d exp=960", q.size()); end
    else begin
      total++;
      if (q[959].addr !== 17'd639 || q[959].plane != 2 || q[959].data !== 8'hBF) begin
        bad++; $display("FAIL surplus_last addr=%0d plane=%0d data=%h exp=639/2/bf", q[959].addr, q[959].plane, q[959].data);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL surplus_status err=%0d busy=%b exp=0/0", bus.err_cnt, bus.busy);
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] b;
    do_reset();
    send_pkt(7, 100, 1'b1);
    RST = 1'b1;
    drive_byte(8'd100);
    RST = 1'b0;
    total++;
    if ({bus.wea_r, bus.wea_g, bus.wea_b} !== 3'b000 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_edge wea=%b busy=%b exp=000/1", {bus.wea_r, bus.wea_g, bus.wea_b}, bus.busy);
    end
    for (int k = 101; k < 150; k++) begin
      b = k[7:0];
      drive_byte(b);
    end
    bus.data_en = 1'b0;
    tick();
    tick();
    total++;
    if (q.size() !== 100) begin bad++; $display("FAIL rstmid_count got=%0d exp=100", q.size()); end
    else begin
      total++;
      if (q[99].addr !== 17'd2273 || q[99].plane != 0) begin
        bad++; $display("FAIL rstmid_last addr=%0d plane=%0d exp=2273/0", q[99].addr, q[99].plane);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_status err=%0d busy=%b exp=0/0", bus.err_cnt, bus.busy);
    end
    send_pkt(8, 960, 1'b0);
    total++;
    if (q.size() !== 1060) begin bad++; $display("FAIL rstmid_next_count got=%0d exp=1060", q.size()); end
    else begin
      total++;
      if (q[100].addr !== 17'd2560 || q[1059].addr !== 17'd2879) begin
        bad++; $display("FAIL rstmid_next_addr first=%0d last=%0d exp=2560/2879", q[100].addr, q[1059].addr);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_next_err got=%0d exp=0", bus.err_cnt); end
  endtask

  task automatic test_err_sat();
    do_reset();
    drive_byte(8'h00);
    bus.data_en = 1'b0;
    tick();
    tick();
    total++;
    if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL sat_hdr_short got=%0d exp=1", bus.err_cnt); end
    for (int i = 0; i < 254; i++) send_pkt(300, 0, 1'b0);
    total++;
    if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d exp=255", bus.err_cnt); end
    send_pkt(300, 0, 1'b0);
    total++;
    if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", bus.err_cnt); end
    total++;
    if (q.size() !== 0 || multi != 0) begin
      bad++; $display("FAIL sat_nostrobe strobes=%0d multi=%0d exp=0/0", q.size(), multi);
    end
  endtask

  initial begin
    bus.data_in = 8'h00;
    bus.data_en = 1'b0;
    test_reset();
    test_line5();
    test_frame_done();
    test_bad_line();
    test_truncated();
    test_surplus();
    test_rst_mid();
    test_err_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_wr_ctrl.md
VRAM_WR_CTRL -- requirements
Module: vram_wr_ctrl

Interface
REQ-001 Parameter H_PIX, default 320, pixels per line.
REQ-002 Parameter V_LINES, default 240, lines per frame.
REQ-003 Parameter AW, default 17, VRAM address width; H_PIX*V_LINES SHALL fit in AW bits.
REQ-004 clk  input  1  single clock, the 125MHz Ethernet receive byte clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  8  received payload byte.
REQ-007 data_en  input  1  byte valid; one contiguous high run = one packet.
REQ-008 addr2vram  output  AW  VRAM port-A write address, shared by the three planes.
REQ-009 data_rgb  output  8  VRAM write data, shared by the three planes.
REQ-010 wea_r / wea_g / wea_b  output  1 each  per-plane write strobes; at most one high per cycle.
REQ-011 frame_done  output  1  one-cycle pulse on completion of line V_LINES-1.
REQ-012 busy  output  1  high while in any state other than IDLE.
REQ-013 err_cnt  output  8  count of malformed packets, saturating at 255.

Function
REQ-014 Packet format SHALL be: byte0 = line[15:8], byte1 = line[7:0], then 3*H_PIX payload bytes ordered R,G,B per pixel, pixel 0 first.
REQ-015 FSM states SHALL be IDLE, HDR0, HDR1, PIX, DROP.
REQ-016 IDLE: data_en high -> capture byte0, go to HDR1; data_en low -> stay IDLE. HDR0 is the reset-exit wait: stay in HDR0 while data_en high, go to IDLE when data_en low.
REQ-017 HDR1: data_en high with {byte0,data_in} < V_LINES -> register base = line*H_PIX (AW bits, no truncation), clear pixel/plane counters, go to PIX.
REQ-018 HDR1: data_en high with line >= V_LINES -> err_cnt+1, go to DROP; data_en low in HDR1 -> err_cnt+1, go to IDLE.
REQ-019 PIX: each byte with data_en high SHALL produce, on the next cycle, addr2vram = base+pixel, data_rgb = byte, and the strobe for plane (0=R, 1=G, 2=B).
REQ-020 Plane counter SHALL wrap 2->0, incrementing pixel on wrap; no other address arithmetic.
REQ-021 Write latency SHALL be exactly 1 cycle from the accepted byte to the strobe; strobes are registered outputs.
REQ-022 After byte 3*H_PIX-1 is accepted: data_en low on the next cycle -> IDLE; data_en still high -> DROP, surplus bytes ignored, no error.
REQ-023 PIX: data_en low before 3*H_PIX bytes -> err_cnt+1, go to IDLE; already written bytes remain written.
REQ-024 DROP: no strobes; go to IDLE on the first cycle data_en is low.
REQ-025 frame_done SHALL assert in the same cycle as the final wea_b of a complete line V_LINES-1; lines SHALL be accepted in any order, and no frame assembly is tracked.
REQ-026 err_cnt SHALL hold at 255 on further errors; two errors can never occur in one cycle.
REQ-027 A new packet SHALL need data_en low for at least 1 cycle since the previous packet; an unbroken high run counts as one packet.
REQ-028 Outside PIX, wea_r/g/b SHALL be low; addr2vram and data_rgb hold their last values.

Reset
REQ-029 RST high on a clock edge SHALL set state = HDR0, wea_r/g/b = 0, frame_done = 0, err_cnt = 0, addr2vram = 0, data_rgb = 0, counters = 0; busy = 1 while in HDR0.
REQ-030 RST SHALL take priority over all inputs, including mid-packet; no strobe SHALL be issued in the cycle after RST.
REQ-031 After RST release with data_en high, the partial packet SHALL be discarded via HDR0 without err_cnt change.

Verification
REQ-032 Line 5, 960 bytes 0x00..: first strobe wea_r at addr 1600 data 0x00; last strobe wea_b at addr 1919; 960 strobes total; err_cnt 0.
REQ-033 Line 239 complete packet -> frame_done high exactly one cycle, coincident with wea_b at addr 76799.
REQ-034 Header line 240 (0x00F0) with 960 bytes -> zero strobes, err_cnt 1, busy until data_en falls.
REQ-035 Line 0 truncated after 4 payload bytes -> strobes R@0, G@0, B@0, R@1, then err_cnt 1, IDLE; next valid packet is written normally.
REQ-036 Line 1 with 965 bytes -> 960 strobes ending at addr 639, last 5 bytes ignored, err_cnt 0.
REQ-037 RST pulsed during payload byte 100 with data_en held high -> no strobes until data_en falls; next packet is accepted; err_cnt 0. Separately, 256 bad headers leave err_cnt at 255.
